// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Shares the register file's single write port between the
//             pipeline writeback stage and the multiply/divide unit.
//             Writeback normally wins. Multdiv results wait in a small FIFO
//             and retire into idle write slots. A head entry that has lost
//             MAX_WAIT times forces a one-cycle writeback stall to drain.
//             pend_mask flags registers that still have queued writes.
//  Ports    : clock, ctrl_reset (sync, active-high)
//             wb_valid/wb_reg/wb_data   -> writeback request, wb_stall out
//             md_valid/md_reg/md_data   -> multdiv offer, md_ready out
//             ctrl_writeEnable/ctrl_writeReg/data_writeReg -> regfile port
//             pend_mask                 -> registers with queued writes
//  Config   : REGFILE_WARB_BYPASS_EN - when defined, an md result offered
//             while the FIFO is empty and writeback is idle goes straight
//             to the write port in the same cycle instead of enqueuing.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,   // FIFO entries, power of two, >= 2
    parameter int MAX_WAIT = 4    // losses tolerated before a forced drain
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pend_mask
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_AGE_W = $clog2(MAX_WAIT + 1);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(MAX_WAIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]          r_reg_mem  [DEPTH];
    logic [31:0]         r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_AGE_W-1:0]  r_age;

    // ------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_force;
    logic w_bypass;
    logic w_head_win;
    logic w_wb_win;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // The head has been passed over MAX_WAIT times: it takes the port now.
    assign w_force = !ctrl_reset && !w_empty && (r_age == c_AGE_MAX);

`ifdef REGFILE_WARB_BYPASS_EN
    // Empty FIFO and idle writeback: no reason to spend a cycle queuing.
    assign w_bypass = md_valid && w_empty && !wb_valid && !ctrl_reset;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head_win = !ctrl_reset && !w_empty && (w_force || !wb_valid);
    assign w_wb_win   = !ctrl_reset && wb_valid && !w_force;

    // No look-ahead on a same-cycle pop: a full FIFO refuses even if it
    // is draining this cycle.
    assign md_ready = !w_full && !ctrl_reset;

    // x0 results complete the handshake but are never stored.
    assign w_push = md_valid && md_ready && (md_reg != 5'd0) && !w_bypass;
    assign w_pop  = w_head_win;

    // ------------------------------------------------------------------
    // Pointer / occupancy / age registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_age    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A non-empty FIFO that did not pop lost to writeback; any new
            // head (after a pop or into an empty FIFO) starts fresh.
            if (w_pop || w_empty) begin
                r_age <= '0;
            end else if (r_age != c_AGE_MAX) begin
                r_age <= r_age + c_AGE_W'(1);
            end
        end
    end

    // Entry storage carries no control meaning, so it is not reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_reg_mem[r_wr_ptr]  <= md_reg;
            r_data_mem[r_wr_ptr] <= md_data;
        end
    end

    // ------------------------------------------------------------------
    // Write-port mux
    // ------------------------------------------------------------------
    logic        w_sel_valid;
    logic [4:0]  w_sel_reg;
    logic [31:0] w_sel_data;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_reg   = 5'd0;
        w_sel_data  = 32'd0;
        if (w_head_win) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = r_reg_mem[r_rd_ptr];
            w_sel_data  = r_data_mem[r_rd_ptr];
        end else if (w_wb_win) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = wb_reg;
            w_sel_data  = wb_data;
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = md_reg;
            w_sel_data  = md_data;
        end
    end

    assign ctrl_writeEnable = w_sel_valid && (w_sel_reg != 5'd0);
    assign ctrl_writeReg    = w_sel_reg;
    assign data_writeReg    = w_sel_data;
    assign wb_stall         = w_force && wb_valid;

    // ------------------------------------------------------------------
    // Pending-destination mask: slot i is live when its distance from the
    // read pointer (mod DEPTH) is below the occupancy.
    // ------------------------------------------------------------------
    logic [31:0] w_pend;

    always_comb begin
        w_pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, c_PTR_W'(i) - r_rd_ptr} < r_count) begin
                w_pend[r_reg_mem[i]] = 1'b1;
            end
        end
    end

    assign pend_mask = ctrl_reset ? 32'd0 : w_pend;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Purpose  : Self-checking bench for regfile_write_arbiter. A queue-based
//             reference model predicts every output each cycle; directed
//             sequences add literal expectations, then random traffic runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_stall;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_reg = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pend_mask;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .wb_stall         (wb_stall),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pend_mask        (pend_mask)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of pending results plus the head's age.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   age = 0;

    logic        e_ready, e_stall, e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data, e_pend;
    logic        m_pop, m_push;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_eval();
        logic frc, byp, sel;
        e_ready = 0; e_stall = 0; e_we = 0; e_reg = 0; e_data = 0; e_pend = 0;
        m_pop = 0; m_push = 0; sel = 0;
        if (!ctrl_reset) begin
            e_ready = (q.size() < DEPTH);
            frc = (q.size() > 0) && (age == MAX_WAIT);
`ifdef REGFILE_WARB_BYPASS_EN
            byp = md_valid && (q.size() == 0) && !wb_valid;
`else
            byp = 1'b0;
`endif
            if (frc || (q.size() > 0 && !wb_valid)) begin
                sel = 1; e_reg = q[0].r; e_data = q[0].d; m_pop = 1;
            end else if (wb_valid) begin
                sel = 1; e_reg = wb_reg; e_data = wb_data;
            end else if (byp) begin
                sel = 1; e_reg = md_reg; e_data = md_data;
            end
            e_we    = sel && (e_reg != 0);
            e_stall = frc && wb_valid;
            foreach (q[k]) e_pend[q[k].r] = 1'b1;
            m_push = md_valid && e_ready && (md_reg != 0) && !byp;
        end
    endtask

    task automatic model_update();
        int was;
        model_eval();
        if (ctrl_reset) begin
            q.delete();
            age = 0;
        end else begin
            was = q.size();
            if (m_pop) begin
                void'(q.pop_front());
                age = 0;
            end else if (was > 0) begin
                if (age < MAX_WAIT) age = age + 1;
            end else begin
                age = 0;
            end
            if (m_push) q.push_back('{r: md_reg, d: md_data});
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        model_eval();
        chk("md_ready", md_ready, e_ready);
        chk("wb_stall", wb_stall, e_stall);
        chk("writeEnable", ctrl_writeEnable, e_we);
        chk("pend_mask", pend_mask, e_pend);
        if (e_we) begin
            chk("writeReg", ctrl_writeReg, e_reg);
            chk("writeData", data_writeReg, e_data);
        end
    endtask

    // One cycle: retire the previous cycle's inputs into the model at the
    // edge, drive new inputs on the falling edge, then check.
    task automatic apply(input logic rst, input logic wv, input logic [4:0] wr,
                         input logic [31:0] wd, input logic mv,
                         input logic [4:0] mr, input logic [31:0] md);
        @(posedge clock);
        model_update();
        @(negedge clock);
        ctrl_reset = rst;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        md_valid = mv; md_reg = mr; md_data = md;
        #1;
        compare();
    endtask

    task automatic idle();
        apply(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset behaviour
        apply(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        apply(1, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
        chk("rst_ready", md_ready, 1'b0);
        chk("rst_we", ctrl_writeEnable, 1'b0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_stall", wb_stall, 1'b0);

        idle();
        chk("idle_ready", md_ready, 1'b1);
        chk("idle_we", ctrl_writeEnable, 1'b0);
        chk("idle_pend", pend_mask, 32'd0);
        chk("idle_stall", wb_stall, 1'b0);

        // Plain writeback
        apply(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        chk("wb_we", ctrl_writeEnable, 1'b1);
        chk("wb_reg", ctrl_writeReg, 5'd5);
        chk("wb_data", data_writeReg, 32'hDEADBEEF);
        apply(0, 1, 5'd0, 32'hCAFEF00D, 0, 5'd0, 32'd0);
        chk("wb_x0_we", ctrl_writeEnable, 1'b0);

        // Single md result with writeback idle
        apply(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h12345678);
`ifdef REGFILE_WARB_BYPASS_EN
        chk("byp_we", ctrl_writeEnable, 1'b1);
        chk("byp_reg", ctrl_writeReg, 5'd7);
        chk("byp_data", data_writeReg, 32'h12345678);
        chk("byp_pend", pend_mask, 32'd0);
        idle();
        chk("byp_after_pend", pend_mask, 32'd0);
        chk("byp_after_we", ctrl_writeEnable, 1'b0);
`else
        chk("md_push_we", ctrl_writeEnable, 1'b0);
        idle();
        chk("md_pend", pend_mask, 32'h80);
        chk("md_we", ctrl_writeEnable, 1'b1);
        chk("md_reg", ctrl_writeReg, 5'd7);
        chk("md_data", data_writeReg, 32'h12345678);
`endif
        idle();
        chk("md_pend_clear", pend_mask, 32'd0);

        // Continuous writeback starving two queued results
        apply(0, 1, 5'd10, 32'hA0, 1, 5'd3, 32'h33);
        apply(0, 1, 5'd10, 32'hA1, 1, 5'd4, 32'h44);
        apply(0, 1, 5'd10, 32'hA2, 0, 5'd0, 32'd0);
        chk("starve_ready", md_ready, 1'b0);
        chk("starve_pend", pend_mask, 32'h18);
        for (int k = 0; k < 2; k++) begin
            apply(0, 1, 5'd10, 32'hB0, 0, 5'd0, 32'd0);
            chk("starve_nostall1", wb_stall, 1'b0);
        end
        apply(0, 1, 5'd10, 32'hB1, 0, 5'd0, 32'd0);
        chk("drain3_stall", wb_stall, 1'b1);
        chk("drain3_reg", ctrl_writeReg, 5'd3);
        chk("drain3_data", data_writeReg, 32'h33);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 5'd10, 32'hC0, 0, 5'd0, 32'd0);
            chk("starve_nostall2", wb_stall, 1'b0);
            chk("starve_wbreg", ctrl_writeReg, 5'd10);
        end
        apply(0, 1, 5'd10, 32'hC1, 0, 5'd0, 32'd0);
        chk("drain4_stall", wb_stall, 1'b1);
        chk("drain4_reg", ctrl_writeReg, 5'd4);
        chk("drain4_data", data_writeReg, 32'h44);
        idle();
        chk("drain_done_pend", pend_mask, 32'd0);

        // Same-cycle push and pop at occupancy DEPTH-1
        apply(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
        apply(0, 0, 5'd0, 32'd0, 1, 5'd11, 32'hBB);
        chk("pp_reg", ctrl_writeReg, 5'd9);
        chk("pp_ready", md_ready, 1'b1);
        idle();
        chk("pp_next_reg", ctrl_writeReg, 5'd11);
        chk("pp_next_data", data_writeReg, 32'hBB);
        chk("pp_next_pend", pend_mask, 32'h800);

        // Reset with two entries queued
        apply(0, 1, 5'd2, 32'h2, 1, 5'd3, 32'h333);
        apply(0, 1, 5'd2, 32'h2, 1, 5'd4, 32'h444);
        apply(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("mrst_pend", pend_mask, 32'd0);
        chk("mrst_we", ctrl_writeEnable, 1'b0);
        idle();
        chk("post_rst_pend", pend_mask, 32'd0);
        chk("post_rst_we", ctrl_writeEnable, 1'b0);
        chk("post_rst_ready", md_ready, 1'b1);
        idle();
        chk("post_rst_we2", ctrl_writeEnable, 1'b0);

        // Random traffic, alternating light and heavy writeback phases
        for (int i = 0; i < 3000; i++) begin
            logic rst, wv, mv;
            logic [4:0] wr, mr;
            int heavy;
            heavy = ((i / 200) % 2 == 1) ? 9 : 5;
            rst = ($urandom_range(0, 149) == 0);
            wv  = ($urandom_range(0, 9) < heavy);
            mv  = ($urandom_range(0, 9) < 6);
            wr  = 5'($urandom_range(0, 31));
            mr  = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            apply(rst, wv, wr, $urandom, mv, mr, $urandom);
        end

        @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multiply/divide unit. Writeback normally has priority. Multdiv results are queued in a small FIFO and retired into idle write slots. If a queued result waits too long, the arbiter stalls writeback for one cycle to drain it. A pending-destination mask lets decode stall on registers that still have queued writes.

## Interface
Parameters:
- DEPTH, 2: multdiv result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4: cycles the FIFO head may wait before a forced drain (≥1)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback stage has a write this cycle
- wb_reg  in  5  writeback destination
- wb_data  in  32  writeback data
- wb_stall  out  1  writeback must hold its write (forced drain cycle)
- md_valid  in  1  multdiv result offered
- md_ready  out  1  FIFO can accept; transfer on md_valid & md_ready at clock edge
- md_reg  in  5  multdiv destination
- md_data  in  32  multdiv result
- ctrl_writeEnable  out  1  to regfile write enable
- ctrl_writeReg  out  5  to regfile write address
- data_writeReg  out  32  to regfile write data
- pend_mask  out  32  bit i = 1 when any valid FIFO entry targets register i

## Operation
- FIFO: DEPTH entries of {reg[4:0], data[31:0]}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy count of 0..DEPTH drives full/empty.
- md_ready = !full & !ctrl_reset. A push while full is impossible, because md_ready is low. md_ready does not look ahead on a same-cycle pop.
- md_reg == 0: the handshake completes but no entry is written (dropped).
- Write-port selection, evaluated every cycle:
  - force = !empty & (age == MAX_WAIT): the FIFO head wins, wb_stall = wb_valid, and the wb write is not performed.
  - else if wb_valid: the wb write wins. The head waits and age increments.
  - else if !empty: the FIFO head wins.
  - else: ctrl_writeEnable = 0.
- A FIFO pop occurs whenever the head wins. Push and pop may occur in the same cycle; occupancy is then unchanged.
- age counter:
  - cleared on pop, on reset, and while empty.
  - increments when the head is valid and loses arbitration.
  - saturates at MAX_WAIT.
- ctrl_writeEnable is asserted only if the selected reg ≠ 0; wb_reg == 0 writes are suppressed.
- pend_mask is combinational from the valid FIFO entries. Decode stalls any instruction reading or writing a masked register, so the arbiter never needs to reorder same-register writes.

## Timing
- Write-port outputs are combinational from the current-cycle wb inputs and the FIFO head. The regfile captures them at the next edge.
- Queued path latency: md accepted at edge N → head visible in cycle N+1 → written at edge N+1 at the earliest.
- Worst-case head wait: MAX_WAIT cycles of continuous wb_valid, then the forced drain. wb_stall lasts exactly one cycle per drained entry.
- Reset values: FIFO empty, pointers 0, age 0. While ctrl_reset is high: md_ready = 0, wb_stall = 0, ctrl_writeEnable = 0, pend_mask = 0.
- Reset asserted mid-operation discards all queued entries at that edge.

## Configuration
- REGFILE_WARB_BYPASS_EN defined: when md_valid, FIFO empty, !wb_valid and not in reset, the md result drives the write port in the same cycle. md_ready = 1 and no entry is pushed.
- REGFILE_WARB_BYPASS_EN undefined: md results are always enqueued, giving a minimum of one cycle of latency.

## Test plan
- Reset then idle: ctrl_writeEnable = 0, md_ready = 1, pend_mask = 0, wb_stall = 0.
- wb_valid only (reg 5, 0xDEADBEEF): same-cycle ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0xDEADBEEF. With wb_reg = 0: ctrl_writeEnable = 0.
- md push (reg 7, 0x12345678) while wb idle, bypass undefined:
  - pend_mask = 0x80 next cycle, write issued that cycle.
  - pend_mask = 0 afterwards.
  - with bypass defined: written in the push cycle and pend_mask stays 0.
- Continuous wb_valid with two md pushes (regs 3, 4), MAX_WAIT = 4:
  - md_ready drops after the second push.
  - after 4 lost cycles, wb_stall = 1 for one cycle and reg 3 is written.
  - 4 cycles later, reg 4 is written the same way.
- Push and pop in the same cycle with FIFO full-minus-one: occupancy unchanged, pointer wraps correctly, data order preserved.
- ctrl_reset asserted with 2 entries queued: next cycle FIFO empty, pend_mask = 0, and no queued write ever reaches the regfile.
